// File: rtl/td4_sequencer.sv
// td4_sequencer: fetch/execute sequencer and instruction decoder for a TD4-style CPU.
// Waits FETCH_WAIT+1 cycles for the instruction ROM, latches the opcode and
// executes it in one cycle. IN instructions stall when no input data is present.
// The carry and zero flags are held here. STATE_DBG exposes the FSM state
// (0=FETCH, 1=EXEC, 2=WAIT_IN, 3=HALT).
//
// IN handshake: IN_VALID means the input port holds data. The data is consumed
// in the cycle where an IN instruction sees IN_VALID high (in EXEC or WAIT_IN).
// That cycle loads A/B from the IN source and pulses IN_ACK for exactly one
// cycle. IN_ACK is never asserted in any other cycle.
`timescale 1ns/1ps
module td4_sequencer #(
    parameter int DATA_W     = 4,
    parameter int FETCH_WAIT = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        INSTR,
    input  logic [DATA_W-1:0] ALU_SUM,
    input  logic              ALU_CARRY,
    input  logic              IN_VALID,
    output logic              IN_ACK,
    output logic [3:0]        LOAD,
    output logic [1:0]        SELECT,
    output logic              PC_INC,
    output logic              CARRY_FLAG,
    output logic              ZERO_FLAG,
    output logic              HALTED,
    output logic [1:0]        STATE_DBG
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_WAIT_IN = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JZ     = 4'b1100;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] ir_q, ir_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       ir_is_in;
    logic [3:0] in_load;

    // IN A and IN B differ only in which register is loaded.
    assign ir_is_in = (ir_q == OP_IN_A) || (ir_q == OP_IN_B);
    assign in_load  = (ir_q == OP_IN_A) ? 4'b0001 : 4'b0010;

    assign CARRY_FLAG = carry_q;
    assign ZERO_FLAG  = zero_q;
    assign STATE_DBG  = state_q;

    // State, counter, instruction register and flag registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            cnt_q   <= 4'd0;
            ir_q    <= 4'd0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Next state: fetch countdown, opcode latch, stall/halt transitions, flag capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        unique case (state_q)
            ST_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    ir_d    = INSTR;
                    cnt_d   = 4'd0;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_EXEC: begin
                if (ir_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (ir_is_in && !IN_VALID) begin
                    state_d = ST_WAIT_IN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT_IN: begin
                if (IN_VALID) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
        // Flags follow any cycle that writes A, B or OUT; LOAD is only nonzero
        // in EXEC or WAIT_IN, so no state qualifier is needed.
        if (LOAD[2:0] != 3'b000) begin
            carry_d = ALU_CARRY;
            zero_d  = (ALU_SUM == '0);
        end
    end

    // Outputs: decoded from IR in EXEC, IN completion in WAIT_IN, quiet otherwise.
    always_comb begin
        LOAD   = 4'b0000;
        SELECT = 2'b00;
        PC_INC = 1'b0;
        IN_ACK = 1'b0;
        HALTED = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                PC_INC = 1'b0;
            end
            ST_EXEC: begin
                PC_INC = 1'b1;
                case (ir_q)
                    OP_ADD_A:  begin LOAD = 4'b0001; SELECT = 2'b00; end
                    OP_ADD_B:  begin LOAD = 4'b0010; SELECT = 2'b01; end
                    OP_MOV_AI: begin LOAD = 4'b0001; SELECT = 2'b11; end
                    OP_MOV_BI: begin LOAD = 4'b0010; SELECT = 2'b11; end
                    OP_MOV_AB: begin LOAD = 4'b0001; SELECT = 2'b01; end
                    OP_MOV_BA: begin LOAD = 4'b0010; SELECT = 2'b00; end
                    OP_OUT_B:  begin LOAD = 4'b0100; SELECT = 2'b01; end
                    OP_OUT_I:  begin LOAD = 4'b0100; SELECT = 2'b11; end
                    OP_JMP: begin
                        SELECT = 2'b11;
                        LOAD   = 4'b1000;
                        PC_INC = 1'b0;
                    end
                    OP_JNC: begin
                        SELECT = 2'b11;
                        if (!carry_q) begin
                            LOAD   = 4'b1000;
                            PC_INC = 1'b0;
                        end
                    end
                    OP_JZ: begin
                        SELECT = 2'b11;
                        if (zero_q) begin
                            LOAD   = 4'b1000;
                            PC_INC = 1'b0;
                        end
                    end
                    OP_HALT: begin
                        PC_INC = 1'b0;
                    end
                    OP_IN_A, OP_IN_B: begin
                        SELECT = 2'b10;
                        if (IN_VALID) begin
                            LOAD   = in_load;
                            IN_ACK = 1'b1;
                        end else begin
                            PC_INC = 1'b0;
                        end
                    end
                    default: begin
                        // NOP (1010) and reserved (1101) only advance the PC.
                        LOAD = 4'b0000;
                    end
                endcase
            end
            ST_WAIT_IN: begin
                SELECT = 2'b10;
                if (IN_VALID) begin
                    LOAD   = in_load;
                    IN_ACK = 1'b1;
                    PC_INC = 1'b1;
                end
            end
            ST_HALT: begin
                HALTED = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_td4_sequencer.sv
// Testbench for td4_sequencer: two instances (FETCH_WAIT=0 and FETCH_WAIT=2),
// exercised one at a time while the other is held in reset. Each instruction
// is planned as a per-cycle list of expected outputs from the opcode table,
// then driven and compared cycle by cycle.
`timescale 1ns/1ps
module tb_td4_sequencer;

    localparam int FW0 = 0;
    localparam int FW1 = 2;

    // Expected-vector layout: {sel_dont_care, halted, ack, pc_inc, sel[1:0], load[3:0]}
    localparam logic [9:0] V_IDLE  = 10'b0_0_0_0_00_0000;
    localparam logic [9:0] V_STALL = 10'b0_0_0_0_10_0000;
    localparam logic [9:0] V_HALT  = 10'b0_1_0_0_00_0000;

    logic       clk;
    logic       rst       [2];
    logic [3:0] instr     [2];
    logic [3:0] alu_sum   [2];
    logic       alu_carry [2];
    logic       in_valid  [2];
    logic       in_ack    [2];
    logic [3:0] load      [2];
    logic [1:0] sel       [2];
    logic       pc_inc    [2];
    logic       cf        [2];
    logic       zf        [2];
    logic       halted    [2];
    logic [1:0] dbg       [2];

    logic       m_cf [2];
    logic       m_zf [2];

    int n_checks = 0;
    int n_fail   = 0;

    td4_sequencer #(.DATA_W(4), .FETCH_WAIT(FW0)) u_dut0 (
        .CLK(clk), .RESET(rst[0]), .INSTR(instr[0]), .ALU_SUM(alu_sum[0]),
        .ALU_CARRY(alu_carry[0]), .IN_VALID(in_valid[0]), .IN_ACK(in_ack[0]),
        .LOAD(load[0]), .SELECT(sel[0]), .PC_INC(pc_inc[0]), .CARRY_FLAG(cf[0]),
        .ZERO_FLAG(zf[0]), .HALTED(halted[0]), .STATE_DBG(dbg[0])
    );

    td4_sequencer #(.DATA_W(4), .FETCH_WAIT(FW1)) u_dut1 (
        .CLK(clk), .RESET(rst[1]), .INSTR(instr[1]), .ALU_SUM(alu_sum[1]),
        .ALU_CARRY(alu_carry[1]), .IN_VALID(in_valid[1]), .IN_ACK(in_ack[1]),
        .LOAD(load[1]), .SELECT(sel[1]), .PC_INC(pc_inc[1]), .CARRY_FLAG(cf[1]),
        .ZERO_FLAG(zf[1]), .HALTED(halted[1]), .STATE_DBG(dbg[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Outputs of the cycle in which an opcode completes (IN data present).
    function automatic logic [9:0] spec_decode(input logic [3:0] op, input logic c, input logic z);
        logic [3:0] ld;
        logic [1:0] s;
        logic       ack;
        logic       dc;
        logic       pc;
        ld = 4'b0000; s = 2'b00; ack = 1'b0; dc = 1'b0;
        case (op)
            4'b0000: begin ld = 4'b0001; s = 2'b00; end
            4'b0101: begin ld = 4'b0010; s = 2'b01; end
            4'b0011: begin ld = 4'b0001; s = 2'b11; end
            4'b0111: begin ld = 4'b0010; s = 2'b11; end
            4'b0001: begin ld = 4'b0001; s = 2'b01; end
            4'b0100: begin ld = 4'b0010; s = 2'b00; end
            4'b1001: begin ld = 4'b0100; s = 2'b01; end
            4'b1011: begin ld = 4'b0100; s = 2'b11; end
            4'b1111: begin ld = 4'b1000; s = 2'b11; end
            4'b1110: begin ld = c ? 4'b0000 : 4'b1000; s = 2'b11; end
            4'b1100: begin ld = z ? 4'b1000 : 4'b0000; s = 2'b11; end
            4'b1000: dc = 1'b1;
            4'b0010: begin ld = 4'b0001; s = 2'b10; ack = 1'b1; end
            4'b0110: begin ld = 4'b0010; s = 2'b10; ack = 1'b1; end
            default: ld = 4'b0000;
        endcase
        pc = (op != 4'b1000) && !ld[3];
        return {dc, 1'b0, ack, pc, s, ld};
    endfunction

    function automatic bit is_in(input logic [3:0] op);
        return (op == 4'b0010) || (op == 4'b0110);
    endfunction

    task automatic check_cycle(input int d, input string tag, input logic [9:0] e);
        check_eq($sformatf("d%0d %s LOAD", d, tag), 32'(load[d]), 32'(e[3:0]));
        if (!e[9]) check_eq($sformatf("d%0d %s SELECT", d, tag), 32'(sel[d]), 32'(e[5:4]));
        check_eq($sformatf("d%0d %s PC_INC", d, tag), 32'(pc_inc[d]), 32'(e[6]));
        check_eq($sformatf("d%0d %s IN_ACK", d, tag), 32'(in_ack[d]), 32'(e[7]));
        check_eq($sformatf("d%0d %s HALTED", d, tag), 32'(halted[d]), 32'(e[8]));
        check_eq($sformatf("d%0d %s CARRY", d, tag), 32'(cf[d]), 32'(m_cf[d]));
        check_eq($sformatf("d%0d %s ZERO", d, tag), 32'(zf[d]), 32'(m_zf[d]));
    endtask

    // Starts just after the posedge opening the first FETCH cycle and ends at
    // the same point of the next instruction. abort_at stops after that cycle index.
    task automatic run_instr(input int d, input logic [3:0] op, input logic [3:0] sum,
                             input logic cy, input int stall_in, input int abort_at);
        int         fw;
        int         n;
        int         stall;
        logic [9:0] fin;
        logic [9:0] e;
        logic [9:0] exp_q[$];
        fw    = (d == 0) ? FW0 : FW1;
        stall = is_in(op) ? stall_in : 0;
        fin   = spec_decode(op, m_cf[d], m_zf[d]);
        for (int i = 0; i <= fw; i++) exp_q.push_back(V_IDLE);
        for (int j = 0; j < stall; j++) exp_q.push_back(V_STALL);
        exp_q.push_back(fin);
        n = fw + stall + 2;
        for (int k = 0; k < n; k++) begin
            alu_sum[d]   = 4'($urandom);
            alu_carry[d] = 1'($urandom);
            if (k <= fw) begin
                instr[d]    = op;
                in_valid[d] = 1'($urandom_range(0, 1));
            end else begin
                instr[d] = 4'($urandom);
                if (k == n - 1) begin
                    in_valid[d]  = is_in(op) ? 1'b1 : 1'($urandom_range(0, 1));
                    alu_sum[d]   = sum;
                    alu_carry[d] = cy;
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
            @(negedge clk);
            e = exp_q.pop_front();
            check_cycle(d, $sformatf("op%b c%0d", op, k), e);
            if (k == abort_at) return;
            if (k == n - 1 && fin[2:0] != 3'b000) begin
                m_cf[d] = cy;
                m_zf[d] = (sum == 4'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_halted(input int d, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            instr[d]     = 4'($urandom);
            alu_sum[d]   = 4'($urandom);
            alu_carry[d] = 1'($urandom);
            in_valid[d]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_cycle(d, $sformatf("halt c%0d", k), V_HALT);
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset away from any clock edge, then release after a posedge.
    task automatic reset_mid(input int d);
        @(negedge clk);
        #2;
        rst[d] = 1'b1;
        #1;
        m_cf[d] = 1'b0;
        m_zf[d] = 1'b0;
        check_cycle(d, "async_rst", V_IDLE);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    task automatic release_rst(input int d);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    task automatic test_dut(input int d);
        int         fw;
        logic [3:0] op;
        fw = (d == 0) ? FW0 : FW1;
        release_rst(d);
        // MOV A,3 then ADD A,1
        run_instr(d, 4'b0011, 4'd3, 1'b0, 0, -1);
        run_instr(d, 4'b0000, 4'd4, 1'b0, 0, -1);
        // Flags set, JNC not taken, JZ taken
        run_instr(d, 4'b0000, 4'd0, 1'b1, 0, -1);
        run_instr(d, 4'b1110, 4'd5, 1'b0, 0, -1);
        run_instr(d, 4'b1100, 4'd5, 1'b0, 0, -1);
        // IN A stalled 4 cycles
        run_instr(d, 4'b0010, 4'd9, 1'b0, 4, -1);
        // Randomized program
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            while (op == 4'b1000) op = 4'($urandom);
            run_instr(d, op, 4'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3), -1);
        end
        // Reset in WAIT_IN with flags set beforehand
        run_instr(d, 4'b0101, 4'd0, 1'b1, 0, -1);
        run_instr(d, 4'b0110, 4'd1, 1'b0, 6, fw + 3);
        reset_mid(d);
        run_instr(d, 4'b1111, 4'd0, 1'b0, 0, -1);
        run_instr(d, 4'b1011, 4'd0, 1'b1, 0, -1);
        // HALT, hold for 20 cycles, reset mid-HALT
        run_instr(d, 4'b1000, 4'd0, 1'b0, 0, -1);
        run_halted(d, 20);
        reset_mid(d);
        run_instr(d, 4'b0111, 4'd2, 1'b0, 0, -1);
        rst[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            instr[d]     = 4'd0;
            alu_sum[d]   = 4'd0;
            alu_carry[d] = 1'b0;
            in_valid[d]  = 1'b0;
            m_cf[d]      = 1'b0;
            m_zf[d]      = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_cycle(0, "reset", V_IDLE);
        check_cycle(1, "reset", V_IDLE);
        test_dut(0);
        test_dut(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Parametrised successor to the TD4 combinational instruction decoder.
- Owns the fetch/execute sequencing: waits a configurable number of cycles for instruction ROM latency, latches the opcode, and holds carry and zero flags internally.
- Adds instructions the original set lacks: JZ, HALT and NOP, plus a stalling IN handshake.
- Sits between instruction ROM, register file, ALU and PC; drives the register load enables, the source-mux select and the PC increment.

Parameters:
DATA_W, 4, ALU/register datapath width; the zero flag is computed over DATA_W bits.
FETCH_WAIT, 0, extra ROM wait cycles; FETCH lasts FETCH_WAIT+1 cycles (range 0..15).

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
INSTR  input  4  opcode from instruction ROM; sampled on the last FETCH cycle.
ALU_SUM  input  DATA_W  ALU result of the current EXEC cycle.
ALU_CARRY  input  1  ALU carry-out of the current EXEC cycle.
IN_VALID  input  1  input port holds valid data.
IN_ACK  output  1  one-cycle pulse when IN data is consumed.
LOAD  output  4  load enables: [0]=A, [1]=B, [2]=OUT, [3]=PC.
SELECT  output  2  source-mux select: [0]=SELECTA, [1]=SELECTB; 00=A, 01=B, 10=IN, 11=zero.
PC_INC  output  1  PC increments this cycle.
CARRY_FLAG  output  1  registered carry flag.
ZERO_FLAG  output  1  registered zero flag.
HALTED  output  1  high while in the HALT state.

Behaviour:
- States: FETCH, EXEC, WAIT_IN, HALT. Wait counter is 4 bits. IR is a 4-bit instruction register.
- Reset (async, any state, mid-instruction included):
  - state=FETCH, counter=0, IR=0.
  - CARRY_FLAG=0, ZERO_FLAG=0.
  - All outputs 0 while RESET is high and until the first EXEC.
- FETCH:
  - Counter increments each cycle.
  - When counter==FETCH_WAIT: IR<=INSTR, counter<=0, go to EXEC.
  - All of LOAD, PC_INC and IN_ACK are 0 in FETCH.
- EXEC lasts one cycle. Outputs are decoded from IR, then return to FETCH unless stated otherwise.
  - 0000 ADD A,Im: LOAD=0001, SEL=00.
  - 0101 ADD B,Im: LOAD=0010, SEL=01.
  - 0011 MOV A,Im: LOAD=0001, SEL=11.
  - 0111 MOV B,Im: LOAD=0010, SEL=11.
  - 0001 MOV A,B: LOAD=0001, SEL=01.
  - 0100 MOV B,A: LOAD=0010, SEL=00.
  - 1001 OUT B: LOAD=0100, SEL=01.
  - 1011 OUT Im: LOAD=0100, SEL=11.
  - 1111 JMP: LOAD=1000, SEL=11.
  - 1110 JNC: LOAD=1000 if CARRY_FLAG==0, else 0000; SEL=11.
  - 1100 JZ: LOAD=1000 if ZERO_FLAG==1, else 0000; SEL=11.
  - 1010 NOP: LOAD=0000, SEL=00.
  - 1000 HALT: LOAD=0000; go to HALT. PC_INC=0.
  - 1101 (reserved): executes as NOP.
  - 0010 IN A / 0110 IN B: SEL=10.
    - If IN_VALID: LOAD=0001 / 0010 respectively, IN_ACK=1, go to FETCH.
    - If not IN_VALID: LOAD=0, PC_INC=0, go to WAIT_IN.
- PC_INC=1 in every EXEC cycle except: a taken jump (LOAD[3]=1), HALT, and a stalled IN.
- Flags:
  - Updated at the end of any EXEC/WAIT_IN cycle where LOAD[2:0]!=0.
  - CARRY_FLAG<=ALU_CARRY; ZERO_FLAG<=(ALU_SUM=={DATA_W{0}}).
  - Jumps, NOP, HALT and stalled cycles leave flags unchanged.
- WAIT_IN:
  - SEL=10. LOAD=0, PC_INC=0, IN_ACK=0 while IN_VALID==0.
  - On the first cycle with IN_VALID==1: IN load per IR, IN_ACK=1, PC_INC=1, flag update, go to FETCH.
  - No timeout.
- HALT: HALTED=1; all other outputs 0; flags held. Exit only via RESET.
- Latency: one instruction = FETCH_WAIT+2 cycles when not stalled.
- IN_ACK is never high for more than one consecutive cycle.

Test Plan:
- FETCH_WAIT=0: ROM sequence MOV A,3 ; ADD A,1 -> EXEC cycles at t=1 and t=3; LOAD=0001 both; SEL 11 then 00; PC_INC=1 both.
- FETCH_WAIT=2: MOV B,5 -> LOAD/PC_INC low for 3 cycles, then exactly one EXEC cycle with LOAD=0010, SEL=11.
- DATA_W=4: ADD A,Im with ALU_SUM=0, ALU_CARRY=1 -> CARRY_FLAG=1, ZERO_FLAG=1. Then JNC -> LOAD=0000, PC_INC=1. Then JZ -> LOAD=1000, PC_INC=0.
- IN A with IN_VALID=0 for 4 cycles, then 1 -> LOAD=0 for 4 cycles; then LOAD=0001, SEL=10, IN_ACK=1 for exactly one cycle; FETCH follows.
- HALT -> HALTED=1, outputs 0 for 20 cycles despite INSTR changes. Assert RESET mid-HALT and mid-WAIT_IN -> immediate FETCH, flags 0, HALTED=0.
